// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: sub-word loads/stores, alignment faults, multi-cycle load stall, MEM/WB register.
// Optional perf counters enabled with `define MEM_STAGE_LSU_PERF_EN.
module mem_stage_lsu #(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  rd_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct3_i,
    input  logic        reg_we_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_d_o,
    output logic [4:0]  wb_a_o,
    output logic        wb_we_o,
    output logic [31:0] bp_mem_o,
    output logic        fault_o
`ifdef MEM_STAGE_LSU_PERF_EN
    ,
    output logic [31:0] perf_loads_o,
    output logic [31:0] perf_stores_o,
    output logic [31:0] perf_stall_o
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam bit         MULTI  = (MEM_LAT > 1);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        stall;

    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       rdata;

    logic        misalign, bad_f3, fault, live, legal_load, store_commit;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data, wb_d_n;
    logic [3:0]  be;
    logic [31:0] wdata;

    assign idx   = alu_out_i[ADDR_W+1:2];
    assign lane  = alu_out_i[1:0];
    assign rdata = mem[idx];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        misalign = 1'b0;
        bad_f3   = 1'b0;
        case (funct3_i)
            3'b000: ;
            3'b001: misalign = lane[0];
            3'b010: misalign = |lane;
            3'b100: bad_f3 = mem_we_i;
            3'b101: begin
                bad_f3   = mem_we_i;
                misalign = lane[0];
            end
            default: bad_f3 = 1'b1;
        endcase
    end

    assign fault        = valid_i & (mem_re_i | mem_we_i)
                        & (bad_f3 | misalign | (mem_re_i & mem_we_i));
    assign live         = valid_i & ~flush_i;
    assign legal_load   = live & mem_re_i & ~fault;
    assign store_commit = live & mem_we_i & ~fault & ~rst;

    assign ld_byte = 8'(rdata >> {lane, 3'b000});
    assign ld_half = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (funct3_i)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = rdata;
        endcase
    end

    assign wb_d_n = mem_re_i ? load_data : alu_out_i;

    // Store data is replicated across lanes so the enables alone pick the bytes.
    always_comb begin
        be    = 4'b1111;
        wdata = wd_i;
        case (funct3_i[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{wd_i[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wd_i[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wd_i;
            end
        endcase
    end

    // NOTE: the data array is deliberately not reset; only control state is.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                if (legal_load && MULTI) begin
                    stall   = 1'b1;
                    state_n = WAIT;
                    cnt_n   = LAT_M1;
                end
            end
            WAIT: begin
                if (flush_i || cnt <= 4'd1) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else begin
                    stall = 1'b1;
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    assign stall_o = stall & ~rst;

    // Stalled cycles push a bubble but keep the data fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            fault_o    <= 1'b0;
            wb_d_o     <= 32'd0;
            wb_a_o     <= 5'd0;
            bp_mem_o   <= 32'd0;
        end else if (stall) begin
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            fault_o    <= 1'b0;
        end else begin
            wb_valid_o <= live;
            wb_we_o    <= live & reg_we_i & ~fault;
            fault_o    <= live & fault;
            wb_d_o     <= wb_d_n;
            wb_a_o     <= rd_i;
            bp_mem_o   <= alu_out_i;
        end
    end

`ifdef MEM_STAGE_LSU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads_o  <= 32'd0;
            perf_stores_o <= 32'd0;
            perf_stall_o  <= 32'd0;
        end else begin
            if (legal_load && !stall) perf_loads_o  <= perf_loads_o + 32'd1;
            if (store_commit)         perf_stores_o <= perf_stores_o + 32'd1;
            if (stall_o)              perf_stall_o  <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
